fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the main control decoder. Holds the PC and issues word requests to instruction memory over a req/ready + rvalid interface. Presents each returned 32-bit instruction with its PC to the decoder through a valid/ready handshake. Accepts branch/jump redirects from the execute/decode logic and flushes in-flight fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional misaligned-redirect trap is selected with FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  localparam int          DEFAULT_PC_W = 32;
  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, decoder handoff.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of aligning them.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruct,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            fetch_fault
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] redirect_tgt;
  logic            misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc;
  assign misaligned   = |redirect_pc[1:0];
`else
  assign redirect_tgt = redirect_pc & ~PC_W'(INSTR_BYTES - 1);
  assign misaligned   = 1'b0;
`endif

  assign imem_req  = (state == REQ) && !reset;
  assign imem_addr = pc;

  // A response landing in DRAIN during a redirect still retires the old request,
  // otherwise the FSM would wait forever for a response that never comes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instruct    <= NOP;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (state == FAULT) begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b1;
    end else if (redirect_valid) begin
      pc          <= redirect_tgt;
      instr_valid <= 1'b0;
      if (misaligned) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
      end else begin
        case (state)
          REQ:     state <= imem_ready ? DRAIN : REQ;
          WAIT:    state <= imem_rvalid ? REQ : DRAIN;
          DRAIN:   state <= imem_rvalid ? REQ : DRAIN;
          default: state <= REQ;
        endcase
      end
    end else begin
      case (state)
        REQ: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instruct    <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_W'(INSTR_BYTES);
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, instruction-stream model and protocol checks.
// Covers both builds; FETCH_MISALIGN_TRAP_EN selects the trap expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruct;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruct       (instruct),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ready_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  bit          force_en = 0;
  logic [31:0] force_data = '0;
  logic [31:0] exp_pc = '0;
  int          transfers = 0;
  bit          prev_hold = 0;
  bit          prev_req = 0;
  logic [31:0] prev_instr, prev_pcout, prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'h0000_0000;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, score the handshakes that the next edge will take, then settle past the edge.
  task automatic applyStimulus(input bit ir, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    if (prev_hold) begin
      checkOutput("hold_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("hold_instr", instruct, prev_instr);
      checkOutput("hold_pc", pc_out, prev_pcout);
    end
    if (prev_req) begin
      checkOutput("req_held", {31'b0, imem_req}, 32'd1);
      checkOutput("req_addr", imem_addr, prev_addr);
    end
    instr_ready    = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_data;
        pend        = 0;
      end
    end
    imem_ready = ($urandom_range(99) < ready_pct);
    #1;
    prev_hold = 0;
    prev_req  = 0;
    if (reset) begin
      checkOutput("req_in_reset", {31'b0, imem_req}, 32'd0);
    end else begin
      if (instr_valid && instr_ready) begin
        transfers++;
        checkOutput("xfer_pc", pc_out, exp_pc);
        checkOutput("xfer_instr", instruct, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_req && imem_ready) begin
        checkOutput("one_outstanding", {31'b0, pend}, 32'd0);
        pend      = 1;
        pend_cnt  = $urandom_range(lat_max, lat_min);
        pend_data = force_en ? force_data : mem_word(imem_addr);
        force_en  = 0;
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_hold  = instr_valid && !instr_ready && !redirect_valid;
      prev_req   = imem_req && !imem_ready && !redirect_valid;
      prev_instr = instruct;
      prev_pcout = pc_out;
      prev_addr  = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset     = 1'b1;
    prev_hold = 0;
    prev_req  = 0;
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instruct, 32'd0);
    checkOutput("rst_pc_out", pc_out, 32'd0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'd0);
    reset  = 1'b0;
    pend   = 0;
    exp_pc = 32'h0;
    #1;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd1);
    checkOutput("rst_addr", imem_addr, 32'h0);
  endtask

  initial begin
    int          base;
    logic [31:0] rnd;

    // Zero-wait memory, decoder always ready: 3 cycles per instruction.
    resetDut();
    applyStimulus(1, 0, '0);
    checkOutput("first_not_yet", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1, 0, '0);
    checkOutput("first_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("first_pc", pc_out, 32'h0);
    checkOutput("first_instr", instruct, 32'h8C01_0004);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);
    checkOutput("second_pc", pc_out, 32'h4);
    checkOutput("second_instr", instruct, 32'h0);
    applyStimulus(1, 0, '0);
    checkOutput("two_transfers", transfers, 32'd2);

    // Memory refuses for 4 cycles.
    resetDut();
    ready_pct = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, '0);
      checkOutput("stall_req", {31'b0, imem_req}, 32'd1);
      checkOutput("stall_addr", imem_addr, 32'h0);
      checkOutput("stall_novalid", {31'b0, instr_valid}, 32'd0);
    end
    ready_pct = 100;

    // Decoder back-pressure in HOLD.
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, '0);
      checkOutput("hold_noreq", {31'b0, imem_req}, 32'd0);
    end
    base = transfers;
    applyStimulus(1, 0, '0);
    checkOutput("hold_release", transfers - base, 32'd1);

    // Redirect while waiting; stale 0xDEADBEEF arrives two cycles later and must vanish.
    lat_min = 3; lat_max = 3;
    force_en = 1; force_data = 32'hDEAD_BEEF;
    applyStimulus(0, 0, '0);
    applyStimulus(0, 1, 32'h40);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, '0);
      checkOutput("stale_novalid", {31'b0, instr_valid}, 32'd0);
      checkOutput("stale_nodata", {31'b0, instruct === 32'hDEAD_BEEF}, 32'd0);
    end
    lat_min = 1; lat_max = 1;
    checkOutput("redir_req", {31'b0, imem_req}, 32'd1);
    checkOutput("redir_addr", imem_addr, 32'h40);
    base = transfers;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0);
    checkOutput("redir_xfer", transfers - base, 32'd1);

    // Redirect coincident with request acceptance drains one response.
    applyStimulus(1, 1, 32'h100);
    checkOutput("drain_noreq", {31'b0, imem_req}, 32'd0);
    applyStimulus(1, 0, '0);
    checkOutput("drain_addr", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0);

    // PC wraps from the top word to zero.
    base = transfers;
    applyStimulus(1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, '0);
    checkOutput("wrap_xfers", transfers - base, 32'd2);
    checkOutput("wrap_addr", imem_addr, 32'h4);

    // Misaligned redirect target.
    ready_pct = 0;
    applyStimulus(1, 1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    ready_pct = 100;
    for (int i = 0; i < 4; i++) begin
      checkOutput("trap_fault", {31'b0, fetch_fault}, 32'd1);
      checkOutput("trap_noreq", {31'b0, imem_req}, 32'd0);
      checkOutput("trap_novalid", {31'b0, instr_valid}, 32'd0);
      applyStimulus(1, 1, 32'h200);
    end
    resetDut();
`else
    ready_pct = 100;
    checkOutput("align_fault", {31'b0, fetch_fault}, 32'd0);
    checkOutput("align_req", {31'b0, imem_req}, 32'd1);
    checkOutput("align_addr", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0);
`endif

    // Random traffic against the stream model, with one mid-run reset.
    ready_pct = 70; lat_min = 1; lat_max = 3;
    base = transfers;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) resetDut();
      rnd = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rnd = rnd & 32'hFFFF_FFFC;
`endif
      applyStimulus($urandom_range(99) < 60, $urandom_range(99) < 4, rnd);
      if (!reset) checkOutput("rand_fault", {31'b0, fetch_fault}, 32'd0);
    end
    checkOutput("rand_progress", {31'b0, (transfers - base) > 20}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
